// File: rtl/dsb_coupling_acc.sv
// Coupling accumulator: sums N_NEIGH signed Q8.8 products J*x per request
// and presents a saturated Q8.8 coupling force for the processing element.
module dsb_coupling_acc #(
   parameter int WIDTH   = 16,
   parameter int N_NEIGH = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] j_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] coupling_force,
   output logic             force_valid,
   output logic             sat_flag,
   output logic             busy
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = PW + CNT_W;

   localparam logic signed [AW-1:0] MAXV =
      {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV =
      {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NEIGH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic signed [AW-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] shifted;
   logic [WIDTH-1:0]     res;
   logic                 res_sat;
   logic                 beat;

   assign in_ready = (state == ACCUM);
   assign busy     = (state != IDLE);
   assign beat     = in_valid && in_ready;
   assign prod     = $signed(x_in) * $signed(j_in);
   assign shifted  = acc >>> 8;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (beat && cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Q16.16 sum back to Q8.8 with floor rounding, clamped to WIDTH bits
   always_comb begin
      res     = shifted[WIDTH-1:0];
      res_sat = 1'b0;
      if (shifted > MAXV) begin
         res     = {1'b0, {(WIDTH-1){1'b1}}};
         res_sat = 1'b1;
      end else if (shifted < MINV) begin
         res     = {1'b1, {(WIDTH-1){1'b0}}};
         res_sat = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            acc <= '0;
            cnt <= '0;
         end else if (beat) begin
            acc <= acc + {{CNT_W{prod[PW-1]}}, prod};
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coupling_force <= '0;
         sat_flag       <= 1'b0;
         force_valid    <= 1'b0;
      end else begin
         force_valid <= (state == DONE);
         if (state == DONE) begin
            coupling_force <= res;
            sat_flag       <= res_sat;
         end
      end
   end

endmodule

// File: tb/tb_dsb_coupling_acc.sv
// Scoreboard bench for dsb_coupling_acc: directed Q8.8 vectors with
// hand-computed results, checked by an independent output monitor.
module tb_dsb_coupling_acc;

   localparam int W = 16;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  x_in = '0;
   logic [W-1:0]  j_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  coupling_force;
   logic          force_valid;
   logic          sat_flag;
   logic          busy;

   typedef struct {
      logic [W-1:0] force_v;
      logic         sat;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   dsb_coupling_acc #(.WIDTH(W), .N_NEIGH(N), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .x_in(x_in),
      .j_in(j_in),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .coupling_force(coupling_force),
      .force_valid(force_valid),
      .sat_flag(sat_flag),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every force_valid cycle must match the oldest expectation
   always @(negedge clk) begin
      if (force_valid) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_force: got %0h with empty scoreboard",
                     coupling_force);
         end else begin
            e = sb.pop_front();
            check("coupling_force", int'(coupling_force), int'(e.force_v));
            check("sat_flag", int'(sat_flag), int'(e.sat));
            check("force_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input logic [W-1:0] x, input logic [W-1:0] j,
                      input logic [W-1:0] ef, input logic es,
                      input int stall);
      exp_t e;
      int   c;
      start = 1'b1;
      @(posedge clk);
      c = cyc;
      #1 start = 1'b0;
      e.force_v = ef;
      e.sat     = es;
      e.cyc     = c + N + 2 + stall;
      sb.push_back(e);
      check("in_ready_accum", int'(in_ready), 1);
      for (int b = 0; b < N; b++) begin
         if (b == 2 && stall > 0) begin
            in_valid = 1'b0;
            for (int s = 0; s < stall; s++) begin
               if (s == 1) start = 1'b1;
               @(posedge clk);
               #1 start = 1'b0;
            end
         end
         in_valid = 1'b1;
         x_in = x;
         j_in = j;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("busy_done", int'(busy), 1);
      check("in_ready_done", int'(in_ready), 0);
      if (stall > 0) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      idle_cycles(2);
      check("busy_after", int'(busy), 0);
   endtask

   initial begin
      #2;
      check("rst_force", int'(coupling_force), 0);
      check("rst_valid", int'(force_valid), 0);
      check("rst_ready", int'(in_ready), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle_cycles(2);

      run(16'h0100, 16'h0100, 16'h0400, 1'b0, 0);
      run(16'hFF00, 16'h0080, 16'hFE00, 1'b0, 0);
      run(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 0);
      run(16'h0001, 16'h0001, 16'h0000, 1'b0, 0);
      run(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 0);
      run(16'h8000, 16'h7FFF, 16'h8000, 1'b1, 0);
      run(16'hFF00, 16'h0080, 16'hFE00, 1'b0, 3);

      // abort a run after two beats
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      in_valid = 1'b1;
      x_in = 16'h0100;
      j_in = 16'h0100;
      idle_cycles(2);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_force", int'(coupling_force), 0);
      check("midrst_sat", int'(sat_flag), 0);
      check("midrst_valid", int'(force_valid), 0);
      check("midrst_ready", int'(in_ready), 0);
      check("midrst_busy", int'(busy), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle_cycles(3);

      run(16'h0100, 16'h0100, 16'h0400, 1'b0, 0);
      idle_cycles(10);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
